// File: rtl/clock_set_ctrl.sv
// Set-mode controller for a 12-hour clock: seconds prescaler, button-driven
// hour/minute editing, and a valid/ready load of the edited time.
module clock_set_ctrl #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [7:0] cur_hh,
  input  logic [7:0] cur_mm,
  input  logic       cur_pm,
  output logic       ena,
  output logic       ld_valid,
  output logic [7:0] ld_hh,
  output logic [7:0] ld_mm,
  output logic       ld_pm,
  input  logic       ld_ready,
  output logic [1:0] edit_sel
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_HH = 2'd1,
    SET_MM = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam int             CW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TICK_DIV - 1);

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          mode_q, inc_q;
  logic          mode_edge, inc_edge;
  logic [7:0]    e_hh, e_mm, e_hh_next, e_mm_next;
  logic          e_pm, e_pm_next;

  function automatic logic hh_valid(input logic [7:0] h);
    return (h[7:4] == 4'd0 && h[3:0] != 4'd0 && h[3:0] <= 4'd9) ||
           h == 8'h10 || h == 8'h11 || h == 8'h12;
  endfunction

  function automatic logic mm_valid(input logic [7:0] m);
    return m[7:4] <= 4'd5 && m[3:0] <= 4'd9;
  endfunction

  function automatic logic [7:0] hh_step(input logic [7:0] h);
    if (h == 8'h12)       return 8'h01;
    if (h[3:0] == 4'd9)   return 8'h10;
    return h + 8'h01;
  endfunction

  function automatic logic [7:0] mm_step(input logic [7:0] m);
    if (m[3:0] != 4'd9)   return {m[7:4], m[3:0] + 4'd1};
    if (m[7:4] == 4'd5)   return 8'h00;
    return {m[7:4] + 4'd1, 4'd0};
  endfunction

  assign mode_edge = btn_mode & ~mode_q;
  assign inc_edge  = btn_inc  & ~inc_q;

  // NOTE: every always_comb output is given a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    e_hh_next  = e_hh;
    e_mm_next  = e_mm;
    e_pm_next  = e_pm;
    case (state)
      RUN: begin
        if (mode_edge) begin
          state_next = SET_HH;
          e_hh_next  = hh_valid(cur_hh) ? cur_hh : 8'h12;
          e_mm_next  = mm_valid(cur_mm) ? cur_mm : 8'h00;
          e_pm_next  = cur_pm;
        end
      end
      SET_HH: begin
        // A mode edge always beats a simultaneous inc edge.
        if (mode_edge) begin
          state_next = SET_MM;
        end else if (inc_edge) begin
          e_hh_next = hh_step(e_hh);
          if (e_hh == 8'h11) e_pm_next = ~e_pm;
        end
      end
      SET_MM: begin
        if (mode_edge)     state_next = COMMIT;
        else if (inc_edge) e_mm_next  = mm_step(e_mm);
      end
      COMMIT: begin
        if (ld_ready) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      cnt    <= '0;
      mode_q <= 1'b1;
      inc_q  <= 1'b1;
      e_hh   <= 8'h12;
      e_mm   <= 8'h00;
      e_pm   <= 1'b0;
    end else begin
      state  <= state_next;
      mode_q <= btn_mode;
      inc_q  <= btn_inc;
      e_hh   <= e_hh_next;
      e_mm   <= e_mm_next;
      e_pm   <= e_pm_next;
      // Prescaler only runs in RUN, so leaving COMMIT starts a full period.
      if (state == RUN && cnt != CNT_LAST) cnt <= cnt + CW'(1);
      else                                 cnt <= '0;
    end
  end

  assign ena      = (state == RUN) && (cnt == CNT_LAST);
  assign ld_valid = (state == COMMIT);
  assign ld_hh    = e_hh;
  assign ld_mm    = e_mm;
  assign ld_pm    = e_pm;
  assign edit_sel = state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: per-cycle comparison against an integer-level
// model, plus a scoreboard queue of expected time loads popped at each transfer.
module tb_clock_set_ctrl;
  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, cur_pm = 1'b0, ld_ready = 1'b0;
  logic [7:0] cur_hh = 8'h12, cur_mm = 8'h00;
  logic       ena, ld_valid, ld_pm;
  logic [7:0] ld_hh, ld_mm;
  logic [1:0] edit_sel;

  clock_set_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_hh(cur_hh), .cur_mm(cur_mm), .cur_pm(cur_pm), .ena(ena),
    .ld_valid(ld_valid), .ld_hh(ld_hh), .ld_mm(ld_mm), .ld_pm(ld_pm),
    .ld_ready(ld_ready), .edit_sel(edit_sel)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
    logic       pm;
  } load_t;
  load_t sb_q[$];

  // Model: 0=RUN 1=SET_HH 2=SET_MM 3=COMMIT; hours 1..12 and minutes 0..59 as integers.
  int m_st = 0, m_h = 12, m_m = 0, m_run_cyc = 0;
  bit m_pm = 0, m_prev_mode = 1, m_prev_inc = 1, m_valid = 0;

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_vec();
    logic e_ena;
    e_ena = (m_st == 0) && (m_run_cyc % TD == TD - 1);
    return 32'({2'(m_st), e_ena, m_st == 3, to_bcd(m_h), to_bcd(m_m), m_pm});
  endfunction

  task automatic model_update();
    bit me, ie;
    int hi, lo, v;
    if (reset) begin
      if (m_st == 3 && sb_q.size() > 0) void'(sb_q.pop_back());
      m_st = 0; m_h = 12; m_m = 0; m_pm = 0; m_run_cyc = 0;
      m_prev_mode = 1; m_prev_inc = 1; m_valid = 1;
    end else begin
      me = btn_mode && !m_prev_mode;
      ie = btn_inc && !m_prev_inc;
      m_prev_mode = btn_mode;
      m_prev_inc  = btn_inc;
      case (m_st)
        0: begin
          m_run_cyc++;
          if (me) begin
            m_st = 1;
            hi = int'(cur_hh[7:4]); lo = int'(cur_hh[3:0]); v = hi * 10 + lo;
            m_h = (lo <= 9 && hi <= 1 && v >= 1 && v <= 12) ? v : 12;
            hi = int'(cur_mm[7:4]); lo = int'(cur_mm[3:0]);
            m_m = (lo <= 9 && hi <= 5) ? hi * 10 + lo : 0;
            m_pm = cur_pm;
          end
        end
        1: begin
          if (me) m_st = 2;
          else if (ie) begin
            if (m_h == 11) begin m_h = 12; m_pm = ~m_pm; end
            else if (m_h == 12) m_h = 1;
            else m_h++;
          end
        end
        2: begin
          if (me) begin
            m_st = 3;
            sb_q.push_back({to_bcd(m_h), to_bcd(m_m), m_pm});
          end else if (ie) m_m = (m_m + 1) % 60;
        end
        default: if (ld_ready) begin m_st = 0; m_run_cyc = 0; end
      endcase
    end
  endtask

  // One clock: drive inputs, compare outputs mid-cycle, advance the model at the edge.
  task automatic step(input bit m, input bit i, input bit rdy, input bit rst);
    btn_mode = m; btn_inc = i; ld_ready = rdy; reset = rst;
    @(negedge clk);
    if (m_valid)
      check("cycle_outputs", 32'({edit_sel, ena, ld_valid, ld_hh, ld_mm, ld_pm}), exp_vec());
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic press(input bit m, input bit i);
    step(m, i, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Scoreboard monitor: a transfer happens when valid and ready meet outside reset.
  always @(negedge clk) begin
    load_t exp_ld;
    if (!reset && ld_valid && ld_ready) begin
      check("sb_pending", 32'(sb_q.size()), 32'd1);
      if (sb_q.size() > 0) begin
        exp_ld = sb_q.pop_front();
        check("sb_load", 32'({ld_hh, ld_mm, ld_pm}), 32'(exp_ld));
      end
    end
  end

  initial begin
    int ena_cnt;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // Free-running seconds tick after reset.
    ena_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      step(0, 0, 0, 0);
      ena_cnt += int'(ena);
    end
    check("ena_pulses_12cyc", 32'(ena_cnt), 32'd3);

    // Hour editing across the 11->12->01 boundary.
    cur_hh = 8'h11; cur_mm = 8'h58; cur_pm = 1'b0;
    press(1, 0);
    press(0, 1);
    check("hh_11_to_12", 32'({ld_hh, ld_pm}), 32'({8'h12, 1'b1}));
    press(0, 1);
    check("hh_12_to_01", 32'({ld_hh, ld_pm}), 32'({8'h01, 1'b1}));
    check("edit_sel_hh", 32'(edit_sel), 32'd1);

    // Minute editing across 59->00 without carry.
    press(1, 0);
    press(0, 1);
    press(0, 1);
    check("mm_59_to_00", 32'(ld_mm), 32'h00);
    press(0, 1);
    check("mm_to_01_hh_kept", 32'({ld_hh, ld_mm}), 32'h0101);

    // Commit with a stalled ready, then transfer and resumed tick.
    press(1, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0);
    check("commit_hold_valid", 32'(ld_valid), 32'd1);
    step(0, 0, 1, 0);
    check("valid_drop_after_xfer", 32'(ld_valid), 32'd0);
    for (int k = 0; k < 6; k++) step(0, 0, 0, 0);

    // Invalid hour capture and simultaneous mode+inc edges.
    cur_hh = 8'h13; cur_mm = 8'h7a;
    press(1, 0);
    press(1, 1);
    check("mode_wins_sel", 32'(edit_sel), 32'd2);
    check("bad_hh_clamped", 32'({ld_hh, ld_mm}), 32'h1200);

    // Reset during COMMIT with ready high and mode held through reset.
    step(1, 0, 0, 0);
    step(1, 0, 1, 1);
    check("rst_commit_state", 32'({ld_valid, edit_sel, ld_hh}), 32'({1'b0, 2'd0, 8'h12}));
    for (int k = 0; k < 3; k++) step(1, 0, 0, 0);
    check("held_mode_no_edge", 32'(edit_sel), 32'd0);
    step(0, 0, 0, 0);

    // Randomized traffic in every state.
    for (int k = 0; k < 3000; k++) begin
      cur_hh = $urandom_range(0, 1) ? 8'($urandom) : to_bcd($urandom_range(1, 12));
      cur_mm = $urandom_range(0, 1) ? 8'($urandom) : to_bcd($urandom_range(0, 59));
      cur_pm = 1'($urandom);
      step($urandom_range(0, 5) == 0, 1'($urandom), $urandom_range(0, 2) == 0,
           $urandom_range(0, 299) == 0);
    end

    for (int k = 0; k < 4; k++) step(0, 0, 1, 0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
